// File: rtl/ingress_arb.sv
// Two-port packet-atomic round-robin ingress arbiter with per-port show-ahead FIFOs.
// Optional statistics counters are enabled by defining INGRESS_ARB_STAT_EN.

module ingress_arb_fifo #(
    parameter int unsigned W     = 134,
    parameter int unsigned DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_rd,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_wr;
    logic          w_rd;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Full drops the write; empty drops the read
    assign w_wr    = i_wr && (r_cnt != CW'(DEPTH));
    assign w_rd    = i_rd && (r_cnt != '0);
    assign o_rdata = r_mem[r_rp];
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= f_inc(r_wp);
            end
            if (w_rd) begin
                r_rp <= f_inc(r_rp);
            end
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end
endmodule

module ingress_arb #(
    parameter int unsigned AFULL_TH  = 128,
    parameter int unsigned PKT_DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in0_pkt_wr,
    input  logic [133:0] in0_pkt,
    input  logic         in0_valid_wr,
    input  logic         in0_valid,
    input  logic         in1_pkt_wr,
    input  logic [133:0] in1_pkt,
    input  logic         in1_valid_wr,
    input  logic         in1_valid,
    output logic         out0_pkt_almostfull,
    output logic         out1_pkt_almostfull,
    output logic         out_pkt_wr,
    output logic [133:0] out_pkt,
    output logic         out_valid_wr,
    output logic         out_valid,
    input  logic         in_pkt_almostfull
`ifdef INGRESS_ARB_STAT_EN
    ,
    output logic [31:0]  stat_fwd0_cnt,
    output logic [31:0]  stat_fwd1_cnt,
    output logic [31:0]  stat_drop_cnt
`endif
);
    localparam int unsigned PKT_W     = 134;
    localparam int unsigned VLD_DEPTH = 64;
    localparam int unsigned PCW       = $clog2(PKT_DEPTH + 1);
    localparam int unsigned VCW       = $clog2(VLD_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SEND, DISCARD} state_t;

    state_t           r_state;
    logic             r_grant;
    logic             r_last_grant;
    logic             r_out_pkt_wr;
    logic [PKT_W-1:0] r_out_pkt;
    logic             r_out_valid_wr;
    logic             r_out_valid;
    logic             r_af0;
    logic             r_af1;

    logic [PKT_W-1:0] w_p0_word;
    logic [PKT_W-1:0] w_p1_word;
    logic [PCW-1:0]   w_p0_cnt;
    logic [PCW-1:0]   w_p1_cnt;
    logic             w_v0_head;
    logic             w_v1_head;
    logic [VCW-1:0]   w_v0_cnt;
    logic [VCW-1:0]   w_v1_cnt;

    logic             w_elig0;
    logic             w_elig1;
    logic             w_arb;
    logic             w_pick;
    logic             w_vhead;
    logic             w_vpop0;
    logic             w_vpop1;
    logic [PKT_W-1:0] w_word;
    logic             w_ppop;
    logic             w_ppop0;
    logic             w_ppop1;
    logic             w_tail;

    ingress_arb_fifo #(.W(PKT_W), .DEPTH(PKT_DEPTH)) u_pkt0 (
        .clk(clk), .reset(reset), .i_wr(in0_pkt_wr), .i_wdata(in0_pkt),
        .i_rd(w_ppop0), .o_rdata(w_p0_word), .o_cnt(w_p0_cnt)
    );
    ingress_arb_fifo #(.W(PKT_W), .DEPTH(PKT_DEPTH)) u_pkt1 (
        .clk(clk), .reset(reset), .i_wr(in1_pkt_wr), .i_wdata(in1_pkt),
        .i_rd(w_ppop1), .o_rdata(w_p1_word), .o_cnt(w_p1_cnt)
    );
    ingress_arb_fifo #(.W(1), .DEPTH(VLD_DEPTH)) u_vld0 (
        .clk(clk), .reset(reset), .i_wr(in0_valid_wr), .i_wdata(in0_valid),
        .i_rd(w_vpop0), .o_rdata(w_v0_head), .o_cnt(w_v0_cnt)
    );
    ingress_arb_fifo #(.W(1), .DEPTH(VLD_DEPTH)) u_vld1 (
        .clk(clk), .reset(reset), .i_wr(in1_valid_wr), .i_wdata(in1_valid),
        .i_rd(w_vpop1), .o_rdata(w_v1_head), .o_cnt(w_v1_cnt)
    );

    // A queued valid flag means the whole packet is already resident
    always_comb begin
        w_elig0 = (w_v0_cnt != '0);
        w_elig1 = (w_v1_cnt != '0);
        w_arb   = (r_state == IDLE) && !in_pkt_almostfull && (w_elig0 || w_elig1);
        w_pick  = (w_elig0 && w_elig1) ? ~r_last_grant : w_elig1;
        w_vhead = w_pick ? w_v1_head : w_v0_head;
        w_vpop0 = w_arb && !w_pick;
        w_vpop1 = w_arb && w_pick;
        w_word  = r_grant ? w_p1_word : w_p0_word;
        w_ppop  = ((r_state == SEND) || (r_state == DISCARD)) &&
                  (r_grant ? (w_p1_cnt != '0) : (w_p0_cnt != '0));
        w_ppop0 = w_ppop && !r_grant;
        w_ppop1 = w_ppop && r_grant;
        w_tail  = w_ppop && (w_word[133:132] == 2'b10);
    end

`ifdef INGRESS_ARB_STAT_EN
    logic [31:0] r_fwd0_cnt;
    logic [31:0] r_fwd1_cnt;
    logic [31:0] r_drop_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_grant        <= 1'b0;
            r_last_grant   <= 1'b1;
            r_out_pkt_wr   <= 1'b0;
            r_out_pkt      <= '0;
            r_out_valid_wr <= 1'b0;
            r_out_valid    <= 1'b0;
            r_af0          <= 1'b0;
            r_af1          <= 1'b0;
`ifdef INGRESS_ARB_STAT_EN
            r_fwd0_cnt     <= '0;
            r_fwd1_cnt     <= '0;
            r_drop_cnt     <= '0;
`endif
        end else begin
            r_out_pkt_wr   <= 1'b0;
            r_out_valid_wr <= 1'b0;
            r_af0          <= (w_p0_cnt >= PCW'(AFULL_TH));
            r_af1          <= (w_p1_cnt >= PCW'(AFULL_TH));
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_grant <= w_pick;
                        r_state <= w_vhead ? SEND : DISCARD;
                    end
                end
                SEND: begin
                    if (w_ppop) begin
                        r_out_pkt    <= w_word;
                        r_out_pkt_wr <= 1'b1;
                        if (w_tail) begin
                            r_out_valid_wr <= 1'b1;
                            r_out_valid    <= 1'b1;
                            r_state        <= IDLE;
                            r_last_grant   <= r_grant;
`ifdef INGRESS_ARB_STAT_EN
                            if (r_grant) r_fwd1_cnt <= r_fwd1_cnt + 32'd1;
                            else         r_fwd0_cnt <= r_fwd0_cnt + 32'd1;
`endif
                        end
                    end
                end
                DISCARD: begin
                    if (w_tail) begin
                        r_state      <= IDLE;
                        r_last_grant <= r_grant;
`ifdef INGRESS_ARB_STAT_EN
                        r_drop_cnt   <= r_drop_cnt + 32'd1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_pkt_wr          = r_out_pkt_wr;
    assign out_pkt             = r_out_pkt;
    assign out_valid_wr        = r_out_valid_wr;
    assign out_valid           = r_out_valid;
    assign out0_pkt_almostfull = r_af0;
    assign out1_pkt_almostfull = r_af1;
`ifdef INGRESS_ARB_STAT_EN
    assign stat_fwd0_cnt       = r_fwd0_cnt;
    assign stat_fwd1_cnt       = r_fwd1_cnt;
    assign stat_drop_cnt       = r_drop_cnt;
`endif
endmodule

// File: tb/tb_ingress_arb.sv
// Scoreboard bench for ingress_arb: packet-level round-robin model feeds an expected-word queue.

module tb_ingress_arb;
    typedef struct packed {
        logic         tail;
        logic [133:0] word;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in0_pkt_wr, in1_pkt_wr;
    logic [133:0] in0_pkt, in1_pkt;
    logic         in0_valid_wr, in1_valid_wr;
    logic         in0_valid, in1_valid;
    logic         out0_pkt_almostfull, out1_pkt_almostfull;
    logic         out_pkt_wr;
    logic [133:0] out_pkt;
    logic         out_valid_wr;
    logic         out_valid;
    logic         in_pkt_almostfull;
`ifdef INGRESS_ARB_STAT_EN
    logic [31:0]  stat_fwd0_cnt, stat_fwd1_cnt, stat_drop_cnt;
`endif

    ingress_arb #(.AFULL_TH(128), .PKT_DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .in0_pkt_wr(in0_pkt_wr), .in0_pkt(in0_pkt),
        .in0_valid_wr(in0_valid_wr), .in0_valid(in0_valid),
        .in1_pkt_wr(in1_pkt_wr), .in1_pkt(in1_pkt),
        .in1_valid_wr(in1_valid_wr), .in1_valid(in1_valid),
        .out0_pkt_almostfull(out0_pkt_almostfull),
        .out1_pkt_almostfull(out1_pkt_almostfull),
        .out_pkt_wr(out_pkt_wr), .out_pkt(out_pkt),
        .out_valid_wr(out_valid_wr), .out_valid(out_valid),
        .in_pkt_almostfull(in_pkt_almostfull)
`ifdef INGRESS_ARB_STAT_EN
        ,
        .stat_fwd0_cnt(stat_fwd0_cnt),
        .stat_fwd1_cnt(stat_fwd1_cnt),
        .stat_drop_cnt(stat_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb[$];
    logic [133:0] mw0[$], mw1[$];
    int           ml0[$], ml1[$];
    bit           mv0[$], mv1[$];
    bit           m_lg;
    int           errors, checks, n_out, n_vwr, cyc, last_cyc, last_tail_cyc;
    int           e_fwd0, e_fwd1, e_drop;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Compares every presented output word against the head of the scoreboard
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                last_tail_cyc = -100;
            end else begin
                if (out_valid_wr) n_vwr++;
                if (out_valid_wr && !out_pkt_wr) chk("valid_wr_alone", 134'(out_valid_wr), 134'(0));
                if (out_pkt_wr) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        chk("unexpected_word", out_pkt, 134'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("out_word", out_pkt, e.word);
                        chk("out_valid_wr", 134'(out_valid_wr), 134'(e.tail));
                        if (e.tail) chk("out_valid", 134'(out_valid), 134'(1));
                        if (e.word[133:132] == 2'b01)
                            chk("pkt_gap_ok", 134'((cyc - last_tail_cyc) >= 2), 134'(1));
                        else
                            chk("no_bubble", 134'(cyc - last_cyc), 134'(1));
                        last_cyc = cyc;
                        if (e.tail) last_tail_cyc = cyc;
                    end
                end
            end
        end
    endtask

    task automatic set_valid(input int p, input bit v);
        if (p == 0) begin in0_valid_wr = 1'b1; in0_valid = v; end
        else        begin in1_valid_wr = 1'b1; in1_valid = v; end
    endtask

    task automatic clear_strobes();
        in0_pkt_wr = 1'b0; in1_pkt_wr = 1'b0;
        in0_valid_wr = 1'b0; in1_valid_wr = 1'b0;
    endtask

    // Writes one packet word per cycle, then its flag with or after the tail
    task automatic drive_pkt(input int p, input int n, input bit v);
        logic [133:0] w;
        int mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
            w[131:128] = 4'($urandom);
            w[133:132] = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
            if (p == 0) begin in0_pkt = w; in0_pkt_wr = 1'b1; mw0.push_back(w); end
            else        begin in1_pkt = w; in1_pkt_wr = 1'b1; mw1.push_back(w); end
            if (i == n - 1 && mode == 0) set_valid(p, v);
            tick();
            clear_strobes();
        end
        if (mode != 0) begin
            repeat (mode - 1) tick();
            set_valid(p, v);
            tick();
            clear_strobes();
        end
        if (p == 0) begin ml0.push_back(n); mv0.push_back(v); end
        else        begin ml1.push_back(n); mv1.push_back(v); end
    endtask

    // Resolves all resident packets into output order by alternating ports
    task automatic model_flush();
        exp_t e;
        bit pick;
        bit v;
        int n;
        while (ml0.size() > 0 || ml1.size() > 0) begin
            if (ml0.size() > 0 && ml1.size() > 0) pick = !m_lg;
            else pick = (ml1.size() > 0);
            if (pick) begin n = ml1.pop_front(); v = mv1.pop_front(); end
            else      begin n = ml0.pop_front(); v = mv0.pop_front(); end
            for (int i = 0; i < n; i++) begin
                e.word = pick ? mw1.pop_front() : mw0.pop_front();
                e.tail = (i == n - 1);
                if (v) sb.push_back(e);
            end
            if (!v) e_drop++;
            else if (pick) e_fwd1++;
            else e_fwd0++;
            m_lg = pick;
        end
    endtask

    task automatic drain(input bit randhold);
        int t;
        t = 0;
        while (sb.size() > 0 && t < 3000) begin
            if (randhold) in_pkt_almostfull = ($urandom_range(0, 3) == 0);
            tick();
            t++;
        end
        in_pkt_almostfull = 1'b0;
        repeat (100) tick();
        chk("drain_left", 134'(sb.size()), 134'(0));
`ifdef INGRESS_ARB_STAT_EN
        chk("stat_fwd0", 134'(stat_fwd0_cnt), 134'(e_fwd0));
        chk("stat_fwd1", 134'(stat_fwd1_cnt), 134'(e_fwd1));
        chk("stat_drop", 134'(stat_drop_cnt), 134'(e_drop));
`endif
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_strobes();
        in_pkt_almostfull = 1'b0;
        repeat (3) tick();
        chk("rst_pkt_wr", 134'(out_pkt_wr), 134'(0));
        chk("rst_pkt", out_pkt, 134'(0));
        chk("rst_valid_wr", 134'(out_valid_wr), 134'(0));
        chk("rst_valid", 134'(out_valid), 134'(0));
        chk("rst_af0", 134'(out0_pkt_almostfull), 134'(0));
        chk("rst_af1", 134'(out1_pkt_almostfull), 134'(0));
        sb.delete(); mw0.delete(); mw1.delete();
        ml0.delete(); ml1.delete(); mv0.delete(); mv1.delete();
        m_lg = 1'b1;
        e_fwd0 = 0; e_fwd1 = 0; e_drop = 0;
        reset = 1'b0;
    endtask

    task automatic wait_out(input int base, input int cnt, input string name);
        int t;
        t = 0;
        while (n_out - base < cnt && t < 200) begin tick(); t++; end
        if (n_out - base < cnt) chk(name, 134'(n_out - base), 134'(cnt));
    endtask

    initial begin
        int base, vbase;
        errors = 0; checks = 0; n_out = 0; n_vwr = 0; cyc = 0;
        last_cyc = 0; last_tail_cyc = -100;
        in0_pkt = '0; in1_pkt = '0; in0_valid = 1'b0; in1_valid = 1'b0;
        fork
            monitor();
        join_none
        apply_reset();

        // Three packets per port resident at once: expect 0,1,0,1,0,1
        in_pkt_almostfull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_pkt(0, $urandom_range(2, 6), 1'b1);
            drive_pkt(1, $urandom_range(2, 6), 1'b1);
        end
        model_flush();
        in_pkt_almostfull = 1'b0;
        drain(1'b0);

        // Single 4-word forwarded packet
        drive_pkt(0, 4, 1'b1);
        model_flush();
        drain(1'b0);

        // Discarded 5-word packet then forwarded 2-word packet on port 1
        apply_reset();
        in_pkt_almostfull = 1'b1;
        drive_pkt(1, 5, 1'b0);
        drive_pkt(1, 2, 1'b1);
        model_flush();
        in_pkt_almostfull = 1'b0;
        drain(1'b0);

        // Backpressure in IDLE blocks, backpressure mid-packet does not split
        in_pkt_almostfull = 1'b1;
        drive_pkt(0, 8, 1'b1);
        drive_pkt(0, 8, 1'b1);
        model_flush();
        base = n_out;
        repeat (20) tick();
        chk("hold_no_out", 134'(n_out - base), 134'(0));
        in_pkt_almostfull = 1'b0;
        wait_out(base, 1, "hold_release_timeout");
        in_pkt_almostfull = 1'b1;
        repeat (30) tick();
        chk("atomic_remaining", 134'(sb.size()), 134'(8));
        in_pkt_almostfull = 1'b0;
        drain(1'b0);

        // Almost-full threshold on port 0
        in_pkt_almostfull = 1'b1;
        for (int k = 0; k < 15; k++) drive_pkt(0, 8, 1'b1);
        repeat (2) tick();
        chk("af0_at_120", 134'(out0_pkt_almostfull), 134'(0));
        drive_pkt(0, 8, 1'b1);
        repeat (2) tick();
        chk("af0_at_128", 134'(out0_pkt_almostfull), 134'(1));
        chk("af1_idle", 134'(out1_pkt_almostfull), 134'(0));
        model_flush();
        base = n_out;
        in_pkt_almostfull = 1'b0;
        wait_out(base, 5, "af_drain_timeout");
        chk("af0_cleared", 134'(out0_pkt_almostfull), 134'(0));
        drain(1'b0);

        // Randomized batches with random backpressure while draining
        for (int b = 0; b < 8; b++) begin
            int n0, n1;
            in_pkt_almostfull = 1'b1;
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range(0, 4);
            while (n0 > 0 || n1 > 0) begin
                if (n1 == 0 || (n0 > 0 && $urandom_range(0, 1) == 0)) begin
                    drive_pkt(0, $urandom_range(2, 8), ($urandom_range(0, 3) != 0));
                    n0--;
                end else begin
                    drive_pkt(1, $urandom_range(2, 8), ($urandom_range(0, 3) != 0));
                    n1--;
                end
            end
            model_flush();
            drain(1'b1);
        end

        // Reset while the third word of an 8-word packet is on the output
        in_pkt_almostfull = 1'b0;
        drive_pkt(0, 8, 1'b1);
        model_flush();
        base = n_out;
        vbase = n_vwr;
        wait_out(base, 2, "trunc_start_timeout");
        apply_reset();
        base = n_out;
        repeat (20) tick();
        chk("trunc_no_valid_wr", 134'(n_vwr - vbase), 134'(0));
        chk("flushed_no_out", 134'(n_out - base), 134'(0));
        drive_pkt(0, 3, 1'b1);
        model_flush();
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ingress_arb.md
INGRESS_ARB -- requirements
Module: ingress_arb

Interface
REQ-001 SHALL expose parameter AFULL_TH, default 128: input packet FIFO fill level (words) at or above which that port's almostfull asserts.
REQ-002 SHALL expose parameter PKT_DEPTH, default 256: input packet FIFO depth in 134-bit words; the valid FIFO depth SHALL be 64 entries of 1 bit.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in0_pkt_wr / in1_pkt_wr  in  1  packet word write strobe, port 0 / port 1.
REQ-006 in0_pkt / in1_pkt  in  134  packet word: [133:132] is the tag (01 head, 11 body, 10 tail); [127:0] is data.
REQ-007 in0_valid_wr / in1_valid_wr  in  1  per-packet valid flag write strobe.
REQ-008 in0_valid / in1_valid  in  1  packet disposition: 1 forwards, 0 discards.
REQ-009 out0_pkt_almostfull / out1_pkt_almostfull  out  1  that port's packet FIFO fill level is at or above AFULL_TH.
REQ-010 out_pkt_wr  out  1  merged packet word write strobe.
REQ-011 out_pkt  out  134  merged packet word.
REQ-012 out_valid_wr  out  1  merged valid flag write strobe.
REQ-013 out_valid  out  1  merged valid flag; always 1 when written.
REQ-014 in_pkt_almostfull  in  1  downstream (INGRESS_CTRL input) backpressure.

Function
REQ-015 Each port SHALL own a show-ahead packet FIFO and a show-ahead valid FIFO; head data SHALL be visible while the FIFO is non-empty, and a read SHALL pop it.
REQ-016 Upstream writes the valid flag on or after the packet's tail word; a non-empty valid FIFO SHALL therefore imply that the whole packet is resident.
REQ-017 FSM states SHALL be IDLE, SEND, and DISCARD, and the FSM SHALL hold a 1-bit grant register and a 1-bit last_grant register.
REQ-018 In IDLE, a port SHALL be eligible when its valid FIFO is non-empty; arbitration SHALL occur only when in_pkt_almostfull==0 and at least one port is eligible.
REQ-019 Arbitration SHALL be round-robin: when both ports are eligible, grant goes to the port != last_grant; when one port is eligible, grant goes to that port.
REQ-020 On grant, the block SHALL pop the valid FIFO in that cycle and move to SEND if the head flag is 1, or to DISCARD if it is 0.
REQ-021 In SEND, the block SHALL pop one word per cycle from the granted packet FIFO and register it to out_pkt with out_pkt_wr=1 one cycle later, with no bubbles.
REQ-022 When the popped word has tag 10, out_valid_wr=1 and out_valid=1 SHALL coincide with that word's out_pkt_wr, and the FSM SHALL return to IDLE and set last_grant=grant.
REQ-023 In DISCARD, the block SHALL pop one word per cycle with no output strobes; on tag 10 it SHALL return to IDLE and set last_grant=grant.
REQ-024 in_pkt_almostfull SHALL be sampled only in IDLE; a packet in progress SHALL never be stalled or split (packet-atomic).
REQ-025 There SHALL be exactly one IDLE cycle between consecutive packets, so that the minimum gap between tail and next head on out_pkt is 1 cycle.
REQ-026 Writes to a full input FIFO SHALL be ignored, with no corruption of resident packets.
REQ-027 Strobes are single-cycle; out_pkt and out_valid SHALL hold their last value when their strobes are low.

Reset
REQ-028 While reset==1, all outputs SHALL be 0, both FIFOs of both ports SHALL be flushed, the state SHALL be IDLE, and last_grant SHALL be 1 so that port 0 wins first.
REQ-029 Reset during SEND SHALL truncate the outgoing packet with no out_valid_wr; recovery SHALL begin on the first cycle after reset deasserts.

Configuration
REQ-030 With INGRESS_ARB_STAT_EN defined, the block SHALL add outputs stat_fwd0_cnt[31:0], stat_fwd1_cnt[31:0], and stat_drop_cnt[31:0].
REQ-031 The forward counters SHALL increment on a forwarded tail of port 0 or port 1 respectively.
REQ-032 stat_drop_cnt SHALL increment on a discarded tail.
REQ-033 All three counters SHALL wrap from 0xFFFFFFFF to 0 and SHALL clear on reset.
REQ-034 Without INGRESS_ARB_STAT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Port 0 receives a 4-word packet with valid=1 -> out_pkt shows the same 4 words in consecutive cycles, and out_valid_wr/out_valid=1 occur with word 4.
REQ-036 Both ports hold one complete packet when reset is released -> port 0 is sent first, then port 1 after a 1-cycle gap; with 3 packets per port, output order is 0,1,0,1,0,1.
REQ-037 Port 1 receives a 5-word packet with valid=0, followed by a 2-word packet with valid=1 -> no output for the first packet; the second packet is output; with INGRESS_ARB_STAT_EN, stat_drop_cnt=1 and stat_fwd1_cnt=1.
REQ-038 in_pkt_almostfull=1 held for 20 cycles with packets pending -> no out_pkt_wr; when asserted mid-packet, the current packet completes fully.
REQ-039 128 words written to port 0 -> out0_pkt_almostfull=1, and it clears once the fill level drops below 128.
REQ-040 Reset pulsed at word 3 of an 8-word packet -> no out_valid_wr; FIFOs are empty; a new packet after reset forwards correctly.
